// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for a MIPS-subset datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MEM_WAIT_EN to let MEM stall on mem_ready; otherwise MEM always lasts one cycle.
module multicycle_controller #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src,
  output logic [2:0]         alu_op,
  output logic               ext_sign,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               mem_to_reg,
  output logic               inv_zero,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ILLEGAL = 4'd0,
    I_ADDU    = 4'd1,
    I_ADD     = 4'd2,
    I_SLT     = 4'd3,
    I_JR      = 4'd4,
    I_ADDI    = 4'd5,
    I_ADDIU   = 4'd6,
    I_JAL     = 4'd7,
    I_BEQ     = 4'd8,
    I_BNE     = 4'd9,
    I_LW      = 4'd10,
    I_SW      = 4'd11
  } instr_t;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [2:0] alu_op;
    logic       ext_sign;
  } alu_ctl_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // ALU setup chosen in EXEC and held through MEM/WB so the address/result stays stable
  function automatic alu_ctl_t alu_ctl_f(input instr_t op);
    alu_ctl_t c;
    c = '0;
    case (op)
      I_ADDU, I_ADD: begin
        c.alu_src = 2'd2;
        c.alu_op  = ALU_ADD;
      end
      I_SLT: begin
        c.alu_src = 2'd2;
        c.alu_op  = ALU_SLT;
      end
      I_ADDI, I_ADDIU, I_LW, I_SW: begin
        c.alu_src  = 2'd0;
        c.alu_op   = ALU_ADD;
        c.ext_sign = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic               run_r;
  logic [COUNT_W-1:0] count_r;
  instr_t             op_s;
  alu_ctl_t           alu_s;
  logic               is_rtype_s;
  logic               mem_done_s;
  logic               unused_s;

  logic       ir_wr_s, pc_wr_s, reg_wr_s, ext_sign_s, mem_rd_s, mem_wr_s;
  logic       mem_to_reg_s, inv_zero_s, instr_done_s, illegal_s;
  logic [1:0] pc_src_s, reg_dst_s, alu_src_s;
  logic [2:0] alu_op_s;

`ifdef MEM_WAIT_EN
  assign mem_done_s = mem_ready;
`else
  assign mem_done_s = 1'b1;
`endif

  // Only opcode and funct participate in control decode
  assign unused_s = ^{instruction[25:6], mem_ready};

  // Instruction decode from opcode, and funct for opcode 0
  always_comb begin
    op_s = I_ILLEGAL;
    case (instruction[31:26])
      6'h00: begin
        case (instruction[5:0])
          6'h21:   op_s = I_ADDU;
          6'h20:   op_s = I_ADD;
          6'h2A:   op_s = I_SLT;
          6'h08:   op_s = I_JR;
          default: op_s = I_ILLEGAL;
        endcase
      end
      6'h08:   op_s = I_ADDI;
      6'h09:   op_s = I_ADDIU;
      6'h03:   op_s = I_JAL;
      6'h04:   op_s = I_BEQ;
      6'h05:   op_s = I_BNE;
      6'h23:   op_s = I_LW;
      6'h2B:   op_s = I_SW;
      default: op_s = I_ILLEGAL;
    endcase
  end

  assign alu_s      = alu_ctl_f(op_s);
  assign is_rtype_s = (op_s == I_ADDU) || (op_s == I_ADD) || (op_s == I_SLT);

  // Control outputs and next state; everything is held low until the first edge after reset release
  always_comb begin
    ir_wr_s      = 1'b0;
    pc_wr_s      = 1'b0;
    pc_src_s     = 2'd0;
    reg_wr_s     = 1'b0;
    reg_dst_s    = 2'd0;
    alu_src_s    = 2'd0;
    alu_op_s     = 3'd0;
    ext_sign_s   = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    inv_zero_s   = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    next_state_s = FETCH;
    if (run_r) begin
      case (state_r)
        FETCH: begin
          ir_wr_s      = 1'b1;
          pc_wr_s      = 1'b1;
          pc_src_s     = 2'd0;
          next_state_s = DECODE;
        end
        DECODE: begin
          if (op_s == I_ILLEGAL) begin
            illegal_s    = 1'b1;
            instr_done_s = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = EXEC;
          end
        end
        EXEC: begin
          case (op_s)
            I_ADDU, I_ADD, I_SLT, I_ADDI, I_ADDIU: begin
              {alu_src_s, alu_op_s, ext_sign_s} = alu_s;
              next_state_s = WB;
            end
            I_LW, I_SW: begin
              {alu_src_s, alu_op_s, ext_sign_s} = alu_s;
              next_state_s = MEM;
            end
            I_BEQ, I_BNE: begin
              alu_src_s    = 2'd2;
              alu_op_s     = ALU_SUB;
              ext_sign_s   = 1'b1;
              inv_zero_s   = (op_s == I_BNE);
              pc_src_s     = 2'd1;
              pc_wr_s      = zero ^ (op_s == I_BNE);
              instr_done_s = 1'b1;
              next_state_s = FETCH;
            end
            I_JAL: begin
              reg_wr_s     = 1'b1;
              reg_dst_s    = 2'd2;
              alu_src_s    = 2'd1;
              alu_op_s     = ALU_ADD;
              pc_src_s     = 2'd2;
              pc_wr_s      = 1'b1;
              instr_done_s = 1'b1;
              next_state_s = FETCH;
            end
            I_JR: begin
              pc_src_s     = 2'd3;
              pc_wr_s      = 1'b1;
              instr_done_s = 1'b1;
              next_state_s = FETCH;
            end
            default: next_state_s = FETCH;
          endcase
        end
        MEM: begin
          {alu_src_s, alu_op_s, ext_sign_s} = alu_s;
          if (op_s == I_LW) begin
            mem_rd_s     = 1'b1;
            next_state_s = mem_done_s ? WB : MEM;
          end else if (op_s == I_SW) begin
            mem_wr_s     = 1'b1;
            instr_done_s = mem_done_s;
            next_state_s = mem_done_s ? FETCH : MEM;
          end else begin
            next_state_s = FETCH;
          end
        end
        WB: begin
          {alu_src_s, alu_op_s, ext_sign_s} = alu_s;
          reg_wr_s     = 1'b1;
          reg_dst_s    = is_rtype_s ? 2'd1 : 2'd0;
          mem_to_reg_s = (op_s == I_LW);
          instr_done_s = 1'b1;
          next_state_s = FETCH;
        end
        default: next_state_s = FETCH;
      endcase
    end else begin
      next_state_s = FETCH;
    end
  end

  // State, run-enable and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FETCH;
      run_r   <= 1'b0;
      count_r <= '0;
    end else begin
      run_r   <= 1'b1;
      state_r <= next_state_s;
      if (instr_done_s) begin
        count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign ir_wr       = ir_wr_s;
  assign pc_wr       = pc_wr_s;
  assign pc_src      = pc_src_s;
  assign reg_wr      = reg_wr_s;
  assign reg_dst     = reg_dst_s;
  assign alu_src     = alu_src_s;
  assign alu_op      = alu_op_s;
  assign ext_sign    = ext_sign_s;
  assign mem_rd      = mem_rd_s;
  assign mem_wr      = mem_wr_s;
  assign mem_to_reg  = mem_to_reg_s;
  assign inv_zero    = inv_zero_s;
  assign instr_done  = instr_done_s;
  assign illegal     = illegal_s;
  assign state       = state_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; a second 2-bit-counter instance covers counter wrap.
module tb_multicycle_controller;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;

  logic        ir_wr, pc_wr, reg_wr, ext_sign, mem_rd, mem_wr, mem_to_reg, inv_zero, instr_done, illegal;
  logic [1:0]  pc_src, reg_dst, alu_src;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_count;

  logic [19:0] unused_w_bus;
  logic [1:0]  w_count;

  logic [18:0] ctl;
  int          tests;
  int          fails;

  multicycle_controller #(.COUNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_op(alu_op), .ext_sign(ext_sign), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_to_reg(mem_to_reg), .inv_zero(inv_zero), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_controller #(.COUNT_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .ir_wr(unused_w_bus[0]), .pc_wr(unused_w_bus[1]), .pc_src(unused_w_bus[3:2]),
    .reg_wr(unused_w_bus[4]), .reg_dst(unused_w_bus[6:5]), .alu_src(unused_w_bus[8:7]),
    .alu_op(unused_w_bus[11:9]), .ext_sign(unused_w_bus[12]), .mem_rd(unused_w_bus[13]),
    .mem_wr(unused_w_bus[14]), .mem_to_reg(unused_w_bus[15]), .inv_zero(unused_w_bus[16]),
    .state(unused_w_bus[19:17]), .instr_done(), .illegal(), .instr_count(w_count)
  );

  assign ctl = {ir_wr, pc_wr, pc_src, reg_wr, reg_dst, alu_src, alu_op, ext_sign,
                mem_rd, mem_wr, mem_to_reg, inv_zero, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic ir, input logic pc, input logic [1:0] pcs,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] as,
                                     input logic [2:0] ao, input logic es, input logic mr,
                                     input logic mw, input logic m2r, input logic iz,
                                     input logic dn, input logic il);
    return {ir, pc, pcs, rw, rd, as, ao, es, mr, mw, m2r, iz, dn, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [18:0] c);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".ctl"}, {13'd0, ctl}, {13'd0, c});
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [18:0] f_v, z_v, addu_e, addu_w, lw_e, lw_m, lw_w, bne_t, bne_n, jal_e, ill_d, jr_e, sw_m;
    tests = 0;
    fails = 0;
    f_v    = mk(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    z_v    = 19'd0;
    addu_e = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addu_w = mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    lw_e   = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lw_m   = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lw_w   = mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    bne_t  = mk(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    bne_n  = mk(1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    jal_e  = mk(1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ill_d  = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    jr_e   = mk(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sw_m   = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    reset_n     = 1'b0;
    instruction = 32'h00221821;
    zero        = 1'b0;
    mem_ready   = 1'b1;
    tick;
    tick;
    cyc("reset", 3'd0, z_v);
    chk("reset.count", instr_count, 32'd0);
    reset_n = 1'b1;
    #1;
    cyc("release", 3'd0, z_v);

    // addu: 0,1,2,4
    tick; cyc("addu.F", 3'd0, f_v);
    tick; cyc("addu.D", 3'd1, z_v);
    tick; cyc("addu.E", 3'd2, addu_e);
    tick; cyc("addu.W", 3'd4, addu_w);
    chk("addu.count_pre", instr_count, 32'd0);
    tick; cyc("lw.F", 3'd0, f_v);
    chk("addu.count", instr_count, 32'd1);

    // lw: F D E M W, with MEM stall when enabled
    instruction = 32'h8FBD0004;
    tick; cyc("lw.D", 3'd1, z_v);
    tick; cyc("lw.E", 3'd2, lw_e);
    tick;
    mem_ready = 1'b0;
    #1;
`ifdef MEM_WAIT_EN
    cyc("lw.M0", 3'd3, lw_m);
    tick; cyc("lw.M1", 3'd3, lw_m);
    tick; cyc("lw.M2", 3'd3, lw_m);
    tick;
    mem_ready = 1'b1;
    #1;
`endif
    cyc("lw.M", 3'd3, lw_m);
    tick;
    mem_ready = 1'b1;
    #1;
    cyc("lw.W", 3'd4, lw_w);
    tick; cyc("bne.F", 3'd0, f_v);
    chk("lw.count", instr_count, 32'd2);

    // bne taken (zero=0) then not taken (zero=1)
    instruction = 32'h14220005;
    tick; cyc("bne.D", 3'd1, z_v);
    tick; cyc("bne.E", 3'd2, bne_t);
    tick; cyc("bne2.F", 3'd0, f_v);
    chk("bne.count", instr_count, 32'd3);
    chk("wrap.three", {30'd0, w_count}, 32'd3);
    zero = 1'b1;
    tick; cyc("bne2.D", 3'd1, z_v);
    tick; cyc("bne2.E", 3'd2, bne_n);
    tick; cyc("jal.F", 3'd0, f_v);
    chk("bne2.count", instr_count, 32'd4);
    chk("wrap.zero", {30'd0, w_count}, 32'd0);
    zero = 1'b0;

    // jal
    instruction = 32'h0C000009;
    tick; cyc("jal.D", 3'd1, z_v);
    tick; cyc("jal.E", 3'd2, jal_e);
    tick; cyc("ill.F", 3'd0, f_v);

    // illegal opcode: retires from DECODE
    instruction = 32'hFC000000;
    tick; cyc("ill.D", 3'd1, ill_d);
    tick; cyc("jr.F", 3'd0, f_v);
    chk("ill.count", instr_count, 32'd6);

    // jr
    instruction = 32'h03E00008;
    tick; cyc("jr.D", 3'd1, z_v);
    tick; cyc("jr.E", 3'd2, jr_e);
    tick; cyc("sw.F", 3'd0, f_v);

    // sw
    instruction = 32'hAFBF0000;
    tick; cyc("sw.D", 3'd1, z_v);
    tick; cyc("sw.E", 3'd2, lw_e);
    tick; cyc("sw.M", 3'd3, sw_m);
    tick; cyc("sw2.F", 3'd0, f_v);
    chk("sw.count", instr_count, 32'd8);

    // second sw aborted by reset in MEM
    tick; cyc("sw2.D", 3'd1, z_v);
    tick; cyc("sw2.E", 3'd2, lw_e);
    tick; cyc("sw2.M", 3'd3, sw_m);
    reset_n = 1'b0;
    #1;
    cyc("abort", 3'd0, z_v);
    chk("abort.count", instr_count, 32'd0);
    chk("abort.wcount", {30'd0, w_count}, 32'd0);
    tick;
    reset_n = 1'b1;
    #1;
    cyc("abort.rel", 3'd0, z_v);
    tick; cyc("abort.F", 3'd0, f_v);
    tick; cyc("abort.D", 3'd1, z_v);
    chk("abort.count2", instr_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
